// File: rtl/d_ff_change_fifo.sv
// Change-event capture for a registered WIDTH-bit value: detects changes against the
// previous cycle and queues {old, new} pairs in a FWFT FIFO with a saturating change count.
module d_ff_change_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           q_in,
  input  logic                       en,
  input  logic                       clr,
  output logic                       ev_valid,
  input  logic                       ev_ready,
  output logic [WIDTH-1:0]           ev_old,
  output logic [WIDTH-1:0]           ev_new,
  output logic [$clog2(DEPTH+1)-1:0] ev_level,
  output logic [CNT_W-1:0]           ev_count,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               primed_q, primed_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  logic chg_s, empty_s, full_s, pop_s, push_s;

  // Handshake decode; full/empty come from the level counter, not pointer equality
  always_comb begin
    chg_s   = primed_q & en & (q_in != prev_q);
    empty_s = (level_q == {LW{1'b0}});
    full_s  = (level_q == FULL_LVL);
    pop_s   = ~empty_s & ev_ready;
    push_s  = chg_s & (~full_s | pop_s);
  end

  // Next-state logic; clr overrides push, pop and counting
  always_comb begin
    prev_d   = q_in;
    primed_d = 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      level_d  = {LW{1'b0}};
      cnt_d    = {CNT_W{1'b0}};
      ovf_d    = 1'b0;
    end else begin
      if (pop_s) rd_ptr_d = rd_ptr_q + 1'b1;
      else       rd_ptr_d = rd_ptr_q;
      if (push_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else        wr_ptr_d = wr_ptr_q;
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
      // Dropped events still count
      if (chg_s && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
      else                             cnt_d = cnt_q;
      if (chg_s && full_s && !pop_s) ovf_d = 1'b1;
      else                           ovf_d = ovf_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= {WIDTH{1'b0}};
      primed_q <= 1'b0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      primed_q <= primed_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Event storage; reset clears it so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {(2*WIDTH){1'b0}};
    end else if (push_s && !clr) begin
      mem_q[wr_ptr_q] <= {prev_q, q_in};
    end
  end

  assign ev_valid = ~empty_s;
  assign ev_old   = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
  assign ev_new   = mem_q[rd_ptr_q][WIDTH-1:0];
  assign ev_level = level_q;
  assign ev_count = cnt_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_d_ff_change_fifo.sv
// Self-checking bench for d_ff_change_fifo: directed vector table, hand-written
// reset/saturation sequences, and random stimulus against a queue-based model.
module tb_d_ff_change_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] q_in;
  logic       en, clr, ev_ready;
  logic       ev_valid, overflow;
  logic [2:0] ev_old, ev_new;
  logic [2:0] ev_level;
  logic [7:0] ev_count;

  int checks = 0;
  int errors = 0;

  d_ff_change_fifo #(.WIDTH(3), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .q_in(q_in), .en(en), .clr(clr),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_old(ev_old), .ev_new(ev_new),
    .ev_level(ev_level), .ev_count(ev_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {old,new} pairs plus counters
  logic [5:0] mq[$];
  int         m_cnt;
  logic       m_ovf;
  logic [2:0] m_prev;
  logic       m_primed;

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_ovf = 1'b0; m_prev = 3'd0; m_primed = 1'b0;
  endtask

  task automatic model_edge();
    bit pop, chg;
    pop = (mq.size() > 0) && ev_ready;
    chg = m_primed && en && (q_in != m_prev);
    if (clr) begin
      mq.delete(); m_cnt = 0; m_ovf = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (chg) begin
        if (mq.size() < 4) mq.push_back({m_prev, q_in});
        else m_ovf = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    m_prev = q_in; m_primed = 1'b1;
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] q, input logic e, input logic r, input logic c);
    q_in = q; en = e; ev_ready = r; clr = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag, input int idx);
    chk({tag, "_valid"}, idx, 32'(ev_valid), 32'(mq.size() > 0));
    chk({tag, "_level"}, idx, 32'(ev_level), 32'(mq.size()));
    chk({tag, "_count"}, idx, 32'(ev_count), 32'(m_cnt));
    chk({tag, "_ovf"},   idx, 32'(overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk({tag, "_old"}, idx, 32'(ev_old), 32'(mq[0][5:3]));
      chk({tag, "_new"}, idx, 32'(ev_new), 32'(mq[0][2:0]));
    end
  endtask

  typedef struct {
    logic [2:0] q; logic en; logic rdy; logic clr;
    logic v; logic [2:0] o; logic [2:0] n; int lvl; int cnt; logic ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] q, input logic e, input logic r, input logic c,
                     input logic v, input logic [2:0] o, input logic [2:0] n,
                     input int lvl, input int cnt, input logic ovf);
    vec_t t;
    t.q = q; t.en = e; t.rdy = r; t.clr = c; t.v = v; t.o = o; t.n = n;
    t.lvl = lvl; t.cnt = cnt; t.ovf = ovf;
    tbl.push_back(t);
  endtask

  initial begin
    rst_n = 1'b0; q_in = 3'd0; en = 1'b1; ev_ready = 1'b0; clr = 1'b0;
    model_reset();
    #2;
    chk("rst_valid", 0, 32'(ev_valid), 32'd0);
    chk("rst_level", 0, 32'(ev_level), 32'd0);
    chk("rst_count", 0, 32'(ev_count), 32'd0);
    chk("rst_ovf",   0, 32'(overflow), 32'd0);
    chk("rst_old",   0, 32'(ev_old),   32'd0);
    chk("rst_new",   0, 32'(ev_new),   32'd0);
    #10 rst_n = 1'b1;

    //   q  en r  c   v  old new lvl cnt ovf
    add(0, 1, 0, 0,  0, 0, 0, 0, 0, 0); // priming edge
    add(5, 1, 0, 0,  1, 0, 5, 1, 1, 0); // basic event
    add(6, 1, 0, 0,  1, 0, 5, 2, 2, 0);
    add(7, 1, 0, 0,  1, 0, 5, 3, 3, 0);
    add(7, 1, 1, 0,  1, 5, 6, 2, 3, 0); // ordered drain
    add(7, 1, 1, 0,  1, 6, 7, 1, 3, 0);
    add(7, 1, 1, 0,  0, 0, 0, 0, 3, 0);
    add(7, 1, 1, 0,  0, 0, 0, 0, 3, 0); // pop on empty ignored
    add(0, 1, 0, 0,  1, 7, 0, 1, 4, 0); // overflow fill
    add(1, 1, 0, 0,  1, 7, 0, 2, 5, 0);
    add(2, 1, 0, 0,  1, 7, 0, 3, 6, 0);
    add(3, 1, 0, 0,  1, 7, 0, 4, 7, 0);
    add(4, 1, 0, 0,  1, 7, 0, 4, 8, 1); // dropped, still counted
    add(4, 1, 1, 0,  1, 0, 1, 3, 8, 1);
    add(4, 1, 1, 0,  1, 1, 2, 2, 8, 1);
    add(4, 1, 1, 0,  1, 2, 3, 1, 8, 1);
    add(4, 1, 1, 0,  0, 0, 0, 0, 8, 1);
    add(5, 1, 0, 1,  0, 0, 0, 0, 0, 0); // clr wins over coincident change
    add(5, 1, 0, 0,  0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0,  1, 5, 0, 1, 1, 0); // fill for full+pop
    add(1, 1, 0, 0,  1, 5, 0, 2, 2, 0);
    add(2, 1, 0, 0,  1, 5, 0, 3, 3, 0);
    add(3, 1, 0, 0,  1, 5, 0, 4, 4, 0);
    add(4, 1, 1, 0,  1, 0, 1, 4, 5, 0); // push+pop while full
    add(4, 1, 1, 0,  1, 1, 2, 3, 5, 0);
    add(4, 1, 1, 0,  1, 2, 3, 2, 5, 0);
    add(4, 1, 1, 0,  1, 3, 4, 1, 5, 0); // tail entry
    add(4, 1, 1, 0,  0, 0, 0, 0, 5, 0);
    add(1, 0, 0, 0,  0, 0, 0, 0, 5, 0); // enable gating
    add(2, 0, 0, 0,  0, 0, 0, 0, 5, 0);
    add(6, 0, 0, 0,  0, 0, 0, 0, 5, 0);
    add(6, 1, 0, 0,  0, 0, 0, 0, 5, 0);
    add(4, 1, 0, 0,  1, 6, 4, 1, 6, 0);
    add(4, 1, 1, 0,  0, 0, 0, 0, 6, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].q, tbl[i].en, tbl[i].rdy, tbl[i].clr);
      chk("tbl_valid", i, 32'(ev_valid), 32'(tbl[i].v));
      chk("tbl_level", i, 32'(ev_level), 32'(tbl[i].lvl));
      chk("tbl_count", i, 32'(ev_count), 32'(tbl[i].cnt));
      chk("tbl_ovf",   i, 32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].v) begin
        chk("tbl_old", i, 32'(ev_old), 32'(tbl[i].o));
        chk("tbl_new", i, 32'(ev_new), 32'(tbl[i].n));
      end
    end

    // Mid-cycle async reset with two events queued
    step(3'd5, 1'b1, 1'b0, 1'b0);
    step(3'd2, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_level", 0, 32'(ev_level), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_valid", 0, 32'(ev_valid), 32'd0);
    chk("mrst_level", 0, 32'(ev_level), 32'd0);
    chk("mrst_count", 0, 32'(ev_count), 32'd0);
    chk("mrst_ovf",   0, 32'(overflow), 32'd0);
    model_reset();
    q_in = 3'd7;
    #2 rst_n = 1'b1;
    step(3'd7, 1'b1, 1'b0, 1'b0);
    chk("prime_valid", 0, 32'(ev_valid), 32'd0);
    chk("prime_count", 0, 32'(ev_count), 32'd0);
    step(3'd7, 1'b1, 1'b0, 1'b0);
    chk("prime_hold", 0, 32'(ev_level), 32'd0);
    step(3'd3, 1'b1, 1'b0, 1'b0);
    chk("post_prime_old", 0, 32'(ev_old), 32'd7);
    chk("post_prime_new", 0, 32'(ev_new), 32'd3);
    chk("post_prime_count", 0, 32'(ev_count), 32'd1);

    // Counter saturation: continuous changes with draining
    for (int i = 0; i < 300; i++) begin
      step((i % 2) ? 3'd1 : 3'd2, 1'b1, 1'b1, 1'b0);
      check_model("sat", i);
    end
    chk("sat_final", 0, 32'(ev_count), 32'd255);

    // Randomized stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      step(3'($urandom_range(0, 7)), ($urandom % 4) != 0, ($urandom % 2) != 0,
           ($urandom % 50) == 0);
      check_model("rnd", i);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_ff_change_fifo.md
# d_ff_change_fifo

Change-event capture stage that sits directly downstream of the 3-bit `d_ff` register. Every clock it compares the registered value against the value from the previous cycle. Each detected change is queued as an {old, new} event pair in a small first-word-fall-through FIFO, drained through a valid/ready handshake. It also keeps a saturating count of all detected changes and a sticky overflow flag.

## Interface
- `WIDTH`, 3: width of the monitored value; matches the `d_ff` output.
- `DEPTH`, 4: number of event FIFO entries; power of 2, ≥ 2.
- `CNT_W`, 8: width of the change counter.

- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `q_in`, in, WIDTH: registered value from the upstream `d_ff`.
- `en`, in, 1: detection enable.
- `clr`, in, 1: synchronous clear of the FIFO, count and overflow flag.
- `ev_valid`, out, 1: FIFO head holds an event.
- `ev_ready`, in, 1: consumer accepts the head event.
- `ev_old`, out, WIDTH: head event, value before the change.
- `ev_new`, out, WIDTH: head event, value after the change.
- `ev_level`, out, $clog2(DEPTH+1): number of queued events.
- `ev_count`, out, CNT_W: total changes detected, saturating.
- `overflow`, out, 1: sticky; an event was dropped.

## Operation
- **Reset state.** `rst_n` low clears the following immediately, without waiting for a clock edge:
  - `ev_valid`=0, `ev_old`=`ev_new`=0, `ev_level`=0, `ev_count`=0, `overflow`=0;
  - FIFO pointers = 0, `prev`=0, `primed`=0.
- **Priming.** The first rising edge after reset release loads `prev` from `q_in` and sets `primed`=1. No event is generated on that edge.
- **Prev tracking.** `prev` loads `q_in` on every edge, independent of `en` and `clr`. Re-enabling therefore never reports a stale change.
- **Change detection.** `chg = primed & en & (q_in != prev)`, evaluated combinationally and acted on at the edge.
- **Push.** On `chg`, the pair {`prev`, `q_in`} is written at the write pointer.
- **Pop.** Occurs when `ev_valid & ev_ready` at the edge; the read pointer advances.
- **FWFT head.** `ev_old`/`ev_new` always show the head entry. Their value while `ev_valid`=0 is don't-care; the bench must not check it.
- **Full, push without pop.** The new event is dropped, `overflow` is set, and `ev_level` stays at DEPTH.
- **Full, push with pop.** Both are performed and `ev_level` is unchanged. There is no overflow.
- **Empty.** A pop request is ignored; `ev_valid`=0 so no handshake can complete. A push into an empty FIFO makes `ev_valid`=1 on the next cycle; there is no same-cycle bypass.
- **Counter.** `ev_count` increments on every `chg`, including dropped events. It saturates at 2^CNT_W−1 and never wraps.
- **Pointers.** Pointers wrap modulo DEPTH. Full/empty are decided from the level counter or an extra pointer bit, never from pointer equality alone.
- **clr.** `clr` has priority over push and pop in the same cycle: FIFO empties, `ev_level`=0, `ev_count`=0, `overflow`=0. A change coinciding with `clr` is discarded and not counted.
- **`overflow` clearing.** Only `clr` or reset clears it.

## Timing
- **Push latency.** If `q_in` differs from `prev` at edge N, then after edge N: `ev_valid`=1, `ev_level`+1, `ev_count`+1.
- **Pop latency.** A pop at edge N updates the head and `ev_level` after edge N. Back-to-back pops every cycle are supported.
- **Throughput.** One push and one pop per cycle, sustained.
- **Output timing.**
  - All outputs are registered or decoded from registers.
  - `ev_valid` has no combinational path from `ev_ready` or `q_in`.
  - `ev_ready` may depend combinationally on `ev_valid`.
- **Mid-operation reset.** Reset asserted between edges clears all outputs within the same cycle. After release, one priming edge occurs before detection resumes.

## Test plan
- **Basic event.** Reset, hold `q_in`=0 with `en`=1, `ev_ready`=0. Release reset, then set `q_in`=5 before edge 2. Expect after edge 2: `ev_valid`=1, `ev_old`=0, `ev_new`=5, `ev_level`=1, `ev_count`=1.
- **Ordering.** Drive `q_in` 0→5→6→7 on consecutive edges with `ev_ready`=0. Expect `ev_level`=3. Then raise `ev_ready` and expect pops in order (0,5), (5,6), (6,7), with `ev_valid`=0 after the third pop.
- **Overflow.** With DEPTH=4 and `ev_ready`=0, generate 5 changes. Expect `ev_level`=4, `overflow`=1, `ev_count`=5, and the drain returns only the first 4 events. Then pulse `clr` and expect `ev_level`=0, `ev_count`=0, `overflow`=0.
- **Full with simultaneous pop.** Fill to 4, then change `q_in` 3→4 with `ev_ready`=1 on the same edge. Expect `ev_level` stays 4, `overflow`=0, and the tail entry is (3,4).
- **Enable gating.** With `en`=0, change `q_in` 1→2→6, then set `en`=1 and hold 6. Expect no events and `ev_count` unchanged; the next change 6→4 yields a single event (6,4).
- **Async reset and priming.** Assert `rst_n`=0 mid-cycle with 2 events queued. Expect `ev_valid`=0, `ev_level`=0, `ev_count`=0 before the next edge. After release with `q_in`=7 held, the priming edge must not create an event.
